// File: rtl/approx_mul_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_err_accum
// Purpose  : Error-metric accumulator for approximate multipliers. It takes a
//            stream of (a, b, approx_product) samples, computes the exact a*b
//            internally, and collects the following over a run of NUM_SAMPLES
//            samples: the sum of squared errors, the sum of absolute errors,
//            the maximum absolute error, and the number of mismatches.
// Ports    : clk_i          rising-edge clock
//            rst_ni         asynchronous active-low reset
//            start_i        begin a new run (honoured in IDLE/DONE only)
//            in_valid_i     sample valid
//            in_ready_o     sample accepted when in_valid_i & in_ready_o
//            in_a_i/in_b_i  unsigned operands
//            in_approx_i    approximate product under test
//            busy_o         run in progress (RUN or DRAIN)
//            done_o         results final, held until next start
//            sum_sq_err_o   saturating sum of (approx-exact)^2
//            sum_abs_err_o  saturating sum of |approx-exact|
//            max_abs_err_o  largest |approx-exact| seen this run
//            err_count_o    samples with approx != exact
//            sample_count_o samples accepted this run
//            overflow_o     sticky: an accumulator saturated this run
// Revision : 1.0  initial release
// ============================================================================
module approx_mul_err_accum #(
  parameter int IN_W        = 8,
  parameter int NUM_SAMPLES = 65536,
  parameter int CNT_W       = 17,
  parameter int ACC_W       = 48
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IN_W-1:0]    in_a_i,
  input  logic [IN_W-1:0]    in_b_i,
  input  logic [2*IN_W-1:0]  in_approx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ACC_W-1:0]   sum_sq_err_o,
  output logic [ACC_W-1:0]   sum_abs_err_o,
  output logic [2*IN_W-1:0]  max_abs_err_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [CNT_W-1:0]   sample_count_o,
  output logic               overflow_o
);

  localparam int PW       = 2 * IN_W;   // product width
  localparam int SQ_W     = 2 * PW;     // squared-error width
  // Adder widths are one bit wider than the wider operand so that a carry out
  // of the accumulator range is always visible for saturation.
  localparam int SQ_SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int AB_SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   sample_count_q;
  logic               s1_valid_q, s1_mism_q;
  logic [PW-1:0]      s1_abs_q;
  logic               s2_valid_q, s2_mism_q;
  logic [PW-1:0]      s2_abs_q;
  logic [SQ_W-1:0]    s2_sq_q;
  logic [ACC_W-1:0]   sum_sq_q, sum_abs_q;
  logic [ACC_W-1:0]   sum_sq_d, sum_abs_d;
  logic [PW-1:0]      max_abs_q;
  logic [CNT_W-1:0]   err_count_q;
  logic               overflow_q, done_q;

  logic               w_accept, w_last;
  logic [PW-1:0]      w_exact, w_abs;
  logic [PW:0]        w_err;
  logic [SQ_W-1:0]    w_sq;
  logic [SQ_SUM_W-1:0] w_sq_sum;
  logic [AB_SUM_W-1:0] w_abs_sum;
  logic               w_sq_sat, w_abs_sat;

  // Ready depends on state and count only, never on in_valid_i.
  assign in_ready_o = (state_q == ST_RUN) && (sample_count_q < CNT_W'(NUM_SAMPLES));
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_last     = (sample_count_q == CNT_W'(NUM_SAMPLES - 1));

  // Stage 1: signed difference with one guard bit; |err| always fits in PW bits.
  assign w_exact = {{IN_W{1'b0}}, in_a_i} * {{IN_W{1'b0}}, in_b_i};
  assign w_err   = {1'b0, in_approx_i} - {1'b0, w_exact};
  assign w_abs   = w_err[PW] ? (~w_err[PW-1:0] + PW'(1)) : w_err[PW-1:0];

  // Stage 2: square registered separately so the multiplier and the wide
  // accumulator adder sit in different cycles.
  assign w_sq = {{PW{1'b0}}, s1_abs_q} * {{PW{1'b0}}, s1_abs_q};

  // Saturating accumulation. A clamped accumulator is all-ones, so any further
  // non-zero addend carries out again and it stays clamped.
  assign w_sq_sum  = {{(SQ_SUM_W-ACC_W){1'b0}}, sum_sq_q} + {{(SQ_SUM_W-SQ_W){1'b0}}, s2_sq_q};
  assign w_sq_sat  = |w_sq_sum[SQ_SUM_W-1:ACC_W];
  assign sum_sq_d  = w_sq_sat ? {ACC_W{1'b1}} : w_sq_sum[ACC_W-1:0];

  assign w_abs_sum = {{(AB_SUM_W-ACC_W){1'b0}}, sum_abs_q} + {{(AB_SUM_W-PW){1'b0}}, s2_abs_q};
  assign w_abs_sat = |w_abs_sum[AB_SUM_W-1:ACC_W];
  assign sum_abs_d = w_abs_sat ? {ACC_W{1'b1}} : w_abs_sum[ACC_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      sample_count_q <= '0;
      s1_valid_q     <= 1'b0;
      s1_mism_q      <= 1'b0;
      s1_abs_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_mism_q      <= 1'b0;
      s2_abs_q       <= '0;
      s2_sq_q        <= '0;
      sum_sq_q       <= '0;
      sum_abs_q      <= '0;
      max_abs_q      <= '0;
      err_count_q    <= '0;
      overflow_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      s1_valid_q <= w_accept;
      if (w_accept) begin
        s1_abs_q  <= w_abs;
        s1_mism_q <= |w_err;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sq_q   <= w_sq;
        s2_abs_q  <= s1_abs_q;
        s2_mism_q <= s1_mism_q;
      end

      if (s2_valid_q) begin
        sum_sq_q    <= sum_sq_d;
        sum_abs_q   <= sum_abs_d;
        err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, s2_mism_q};
        if (s2_abs_q > max_abs_q) max_abs_q <= s2_abs_q;
        if (w_sq_sat || w_abs_sat) overflow_q <= 1'b1;
      end

      // The pipeline is always empty in IDLE/DONE, so clearing here never
      // races with an accumulation above.
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q        <= ST_RUN;
            sample_count_q <= '0;
            sum_sq_q       <= '0;
            sum_abs_q      <= '0;
            max_abs_q      <= '0;
            err_count_q    <= '0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            sample_count_q <= sample_count_q + CNT_W'(1);
            if (w_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_q && !s2_valid_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o         = done_q;
  assign sum_sq_err_o   = sum_sq_q;
  assign sum_abs_err_o  = sum_abs_q;
  assign max_abs_err_o  = max_abs_q;
  assign err_count_o    = err_count_q;
  assign sample_count_o = sample_count_q;
  assign overflow_o     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mul_err_accum
// Purpose  : Directed self-checking bench for approx_mul_err_accum. Instance A
//            uses a 48-bit accumulator; instance B uses a 20-bit accumulator
//            to exercise saturation. Both instances run 4-sample runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_approx_mul_err_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A (ACC_W = 48)
  logic        start_a, valid_a, ready_a, busy_a, done_a, ovf_a;
  logic [7:0]  a_a, b_a;
  logic [15:0] ap_a, max_a;
  logic [47:0] sq_a, abs_a;
  logic [2:0]  errc_a, cnt_a;

  // Instance B (ACC_W = 20)
  logic        start_b, valid_b, ready_b, busy_b, done_b, ovf_b;
  logic [7:0]  a_b, b_b;
  logic [15:0] ap_b, max_b;
  logic [19:0] sq_b, abs_b;
  logic [2:0]  errc_b, cnt_b;

  int total = 0;
  int bad   = 0;

  approx_mul_err_accum #(.IN_W(8), .NUM_SAMPLES(4), .CNT_W(3), .ACC_W(48)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .in_valid_i(valid_a),
    .in_ready_o(ready_a), .in_a_i(a_a), .in_b_i(b_a), .in_approx_i(ap_a),
    .busy_o(busy_a), .done_o(done_a), .sum_sq_err_o(sq_a), .sum_abs_err_o(abs_a),
    .max_abs_err_o(max_a), .err_count_o(errc_a), .sample_count_o(cnt_a),
    .overflow_o(ovf_a)
  );

  approx_mul_err_accum #(.IN_W(8), .NUM_SAMPLES(4), .CNT_W(3), .ACC_W(20)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .in_valid_i(valid_b),
    .in_ready_o(ready_b), .in_a_i(a_b), .in_b_i(b_b), .in_approx_i(ap_b),
    .busy_o(busy_b), .done_o(done_b), .sum_sq_err_o(sq_b), .sum_abs_err_o(abs_b),
    .max_abs_err_o(max_b), .err_count_o(errc_b), .sample_count_o(cnt_b),
    .overflow_o(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Presents one sample on a falling edge and returns on the falling edge
  // after the rising edge that accepted it.
  task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] ap);
    int n = 0;
    if (sel == 0) begin valid_a = 1'b1; a_a = a; b_a = b; ap_a = ap; end
    else          begin valid_b = 1'b1; a_b = a; b_b = b; ap_b = ap; end
    while (((sel == 0) ? ready_a : ready_b) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'(n), 64'(0));
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    while (((sel == 0) ? done_a : done_b) !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic chk_results_a(input string tag, input logic [63:0] sq, input logic [63:0] ab,
                               input logic [63:0] mx, input logic [63:0] ec);
    chk({tag, "_sum_sq"},  64'(sq_a),   sq);
    chk({tag, "_sum_abs"}, 64'(abs_a),  ab);
    chk({tag, "_max"},     64'(max_a),  mx);
    chk({tag, "_errcnt"},  64'(errc_a), ec);
    chk({tag, "_count"},   64'(cnt_a),  64'(4));
    chk({tag, "_done"},    64'(done_a), 64'(1));
    chk({tag, "_busy"},    64'(busy_a), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic [15:0] tp [4];

    rst_n = 1'b0;
    start_a = 1'b0; valid_a = 1'b0; a_a = '0; b_a = '0; ap_a = '0;
    start_b = 1'b0; valid_b = 1'b0; a_b = '0; b_b = '0; ap_b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", 64'(ready_a), 64'(0));
    chk("rst_busy",  64'(busy_a),  64'(0));
    chk("rst_done",  64'(done_a),  64'(0));
    chk("rst_count", 64'(cnt_a),   64'(0));
    chk("rst_sum_sq", 64'(sq_a),   64'(0));
    chk("rst_ovf",   64'(ovf_a),   64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: four exact samples
    pulse_start(0);
    chk("t1_busy",  64'(busy_a),  64'(1));
    chk("t1_ready", 64'(ready_a), 64'(1));
    send(0, 8'd1, 8'd2, 16'd2);
    send(0, 8'd3, 8'd4, 16'd12);
    send(0, 8'd10, 8'd10, 16'd100);
    send(0, 8'd255, 8'd255, 16'd65025);
    wait_done(0);
    chk_results_a("t1", 0, 0, 0, 0);
    chk("t1_ready_after", 64'(ready_a), 64'(0));

    // 2: one sample off by one
    pulse_start(0);
    chk("t2_done_cleared",  64'(done_a), 64'(0));
    chk("t2_count_cleared", 64'(cnt_a),  64'(0));
    send(0, 8'd3, 8'd5, 16'd14);
    send(0, 8'd0, 8'd0, 16'd0);
    send(0, 8'd7, 8'd8, 16'd56);
    send(0, 8'd100, 8'd2, 16'd200);
    wait_done(0);
    chk_results_a("t2", 1, 1, 1, 1);

    // 3: large negative error and small positive error
    pulse_start(0);
    send(0, 8'd255, 8'd255, 16'd0);
    send(0, 8'd2, 8'd2, 16'd7);
    send(0, 8'd1, 8'd1, 16'd1);
    send(0, 8'd0, 8'd9, 16'd0);
    wait_done(0);
    chk_results_a("t3", 64'd4228250634, 65028, 65025, 2);

    // 4: same samples with random gaps and stray start pulses
    ta = '{8'd255, 8'd2, 8'd1, 8'd0};
    tb = '{8'd255, 8'd2, 8'd1, 8'd9};
    tp = '{16'd0, 16'd7, 16'd1, 16'd0};
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        start_a = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start_a = 1'b0;
      if (i == 3) chk("t4_ready_before_last", 64'(ready_a), 64'(1));
      send(0, ta[i], tb[i], tp[i]);
    end
    // First falling edge after the last accept: ready must already be low.
    chk("t4_ready_fall", 64'(ready_a), 64'(0));
    chk("t4_done_t0",    64'(done_a),  64'(0));
    // Ignored traffic during DRAIN.
    valid_a = 1'b1; a_a = 8'd1; b_a = 8'd1; ap_a = 16'd500; start_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; start_a = 1'b0;
    chk("t4_done_t1", 64'(done_a), 64'(0));
    @(negedge clk);
    chk("t4_done_t2", 64'(done_a), 64'(0));
    @(negedge clk);
    chk("t4_done_t3", 64'(done_a), 64'(1));
    chk_results_a("t4", 64'd4228250634, 65028, 65025, 2);

    // 5: asynchronous reset in the middle of a run
    pulse_start(0);
    send(0, 8'd3, 8'd5, 16'd14);
    send(0, 8'd2, 8'd2, 16'd7);
    repeat (2) @(negedge clk);
    chk("t5_pre_sum_abs", 64'(abs_a), 64'(4));
    chk("t5_pre_count",   64'(cnt_a), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sum_sq",  64'(sq_a),    64'(0));
    chk("t5_rst_sum_abs", 64'(abs_a),   64'(0));
    chk("t5_rst_max",     64'(max_a),   64'(0));
    chk("t5_rst_errcnt",  64'(errc_a),  64'(0));
    chk("t5_rst_count",   64'(cnt_a),   64'(0));
    chk("t5_rst_ready",   64'(ready_a), 64'(0));
    chk("t5_rst_busy",    64'(busy_a),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_ready", 64'(ready_a), 64'(0));
    pulse_start(0);
    send(0, 8'd3, 8'd5, 16'd14);
    send(0, 8'd0, 8'd0, 16'd0);
    send(0, 8'd7, 8'd8, 16'd56);
    send(0, 8'd100, 8'd2, 16'd200);
    wait_done(0);
    chk_results_a("t5", 1, 1, 1, 1);

    // 6: saturation on the narrow instance
    pulse_start(1);
    for (int i = 0; i < 4; i++) send(1, 8'd255, 8'd255, 16'd0);
    wait_done(1);
    chk("t6_sum_sq",  64'(sq_b),   64'd1048575);
    chk("t6_sum_abs", 64'(abs_b),  64'd260100);
    chk("t6_max",     64'(max_b),  64'd65025);
    chk("t6_errcnt",  64'(errc_b), 64'd4);
    chk("t6_ovf",     64'(ovf_b),  64'd1);
    repeat (5) @(negedge clk);
    chk("t6_ovf_held", 64'(ovf_b), 64'd1);
    pulse_start(1);
    chk("t6_ovf_cleared",    64'(ovf_b), 64'd0);
    chk("t6_sum_sq_cleared", 64'(sq_b),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
